// File: rtl/tick_sched_pkg.sv
// Shared constants for the tick scheduler: channel indices, default periods,
// arbiter state encoding and the round-robin search helper.
package tick_sched_pkg;

    localparam int CH_I = 0;
    localparam int CH_L = 1;
    localparam int CH_D = 2;
    localparam int CH_T = 3;

    localparam int DEF_CNT_W = 26;
    localparam int DEF_PER_I = 8192;
    localparam int DEF_PER_L = 65536;
    localparam int DEF_PER_D = 32768;
    localparam int DEF_PER_T = 50000000;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Returns {found, id}: first set bit of pend searching upward from last+1, wrapping.
    function automatic logic [2:0] rr_pick(input logic [3:0] pend, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (pend[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One strobe channel: programmable period, free-running counter, registered
// single-cycle tick and a level output that toggles with every tick.
module tick_channel #(
    parameter int               CNT_W = 26,
    parameter logic [CNT_W-1:0] DEF_P = CNT_W'(8192)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_data,
    output logic             o_tick,
    output logic             o_level
);

    logic [CNT_W-1:0] r_p;
    logic [CNT_W-1:0] r_c;
    logic             r_tick;
    logic             r_level;
    logic [CNT_W-1:0] w_pe;
    logic             w_wrap;
    logic             w_fire;

    // Periods below 2 would make the tick a constant level, so they clamp to 2.
    assign w_pe   = (r_p < CNT_W'(2)) ? CNT_W'(2) : r_p;
    assign w_wrap = i_run && (r_c == (w_pe - CNT_W'(1)));
    assign w_fire = w_wrap && !i_wr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_p     <= DEF_P;
            r_c     <= '0;
            r_tick  <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_tick  <= w_fire;
            r_level <= r_level ^ w_fire;
            if (i_wr) begin
                r_p <= i_wr_data;
                r_c <= '0;
            end else if (i_run) begin
                r_c <= w_wrap ? '0 : r_c + CNT_W'(1);
            end
        end
    end

    assign o_tick  = r_tick;
    assign o_level = r_level;

endmodule

// File: rtl/tick_scheduler.sv
// Four programmable enable-strobe channels whose service requests are serialised
// to one handler by a round-robin grant/ack arbiter with overrun detection.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEF_I = DEF_PER_I,
    parameter int DEF_L = DEF_PER_L,
    parameter int DEF_D = DEF_PER_D,
    parameter int DEF_T = DEF_PER_T
) (
    input  logic             OCLK,
    input  logic             reset,
    input  logic             run,
    input  logic             wr_en,
    input  logic [1:0]       wr_sel,
    input  logic [CNT_W-1:0] wr_data,
    output logic [3:0]       tick,
    output logic [3:0]       level,
    output logic             grant_valid,
    output logic [1:0]       grant_id,
    input  logic             grant_ack,
    output logic [3:0]       overrun
);

    logic [3:0] w_tick;
    logic [3:0] w_wr;
    logic [3:0] w_clr;
    logic [2:0] w_pick;
    logic       w_ack;
    logic [3:0] r_pend;
    logic [3:0] r_ovr;
    logic [0:0] r_state;
    logic [1:0] r_gid;
    logic [1:0] r_last;

    for (genvar g = 0; g < 4; g++) begin : g_ch
        localparam logic [CNT_W-1:0] DP = (g == CH_I) ? CNT_W'(DEF_I) :
                                          (g == CH_L) ? CNT_W'(DEF_L) :
                                          (g == CH_D) ? CNT_W'(DEF_D) : CNT_W'(DEF_T);
        assign w_wr[g] = wr_en && (wr_sel == 2'(g));

        tick_channel #(.CNT_W(CNT_W), .DEF_P(DP)) u_ch (
            .i_clk     (OCLK),
            .i_reset   (reset),
            .i_run     (run),
            .i_wr      (w_wr[g]),
            .i_wr_data (wr_data),
            .o_tick    (w_tick[g]),
            .o_level   (level[g])
        );
    end

    assign w_ack  = (r_state == ST_GRANT) && grant_ack;
    assign w_clr  = w_ack ? (4'b0001 << r_gid) : 4'b0000;
    assign w_pick = rr_pick(r_pend, r_last);

    always_ff @(posedge OCLK) begin
        if (reset) begin
            r_pend  <= '0;
            r_ovr   <= '0;
            r_state <= ST_IDLE;
            r_gid   <= '0;
            r_last  <= 2'd3;
        end else begin
            // A new tick beats a same-cycle ack; a write to the channel beats a new overrun.
            r_pend <= (r_pend & ~w_clr) | w_tick;
            r_ovr  <= (r_ovr | (w_tick & r_pend & ~w_clr)) & ~w_wr;
            if (r_state == ST_IDLE) begin
                if (w_pick[2]) begin
                    r_state <= ST_GRANT;
                    r_gid   <= w_pick[1:0];
                end
            end else if (grant_ack) begin
                r_state <= ST_IDLE;
                r_last  <= r_gid;
            end
        end
    end

    assign tick        = w_tick;
    assign grant_valid = (r_state == ST_GRANT);
    assign grant_id    = r_gid;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: period table sweep plus hand-written sequences for
// default timing, arbitration order, overrun, write-on-wrap, pause and reset.
module tb_tick_scheduler;

    localparam int CNT_W = 26;

    logic             OCLK = 1'b0;
    logic             reset = 1'b1;
    logic             run = 1'b0;
    logic             wr_en = 1'b0;
    logic [1:0]       wr_sel = 2'd0;
    logic [CNT_W-1:0] wr_data = '0;
    logic             grant_ack = 1'b0;
    logic [3:0]       tick;
    logic [3:0]       level;
    logic             grant_valid;
    logic [1:0]       grant_id;
    logic [3:0]       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int s = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        int ch;
        int wdata;
        int pe;
    } vec_t;
    vec_t vecs[7];

    always #5 OCLK = ~OCLK;
    always @(posedge OCLK) cyc <= cyc + 1;

    tick_scheduler dut (
        .OCLK        (OCLK),
        .reset       (reset),
        .run         (run),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .tick        (tick),
        .level       (level),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .grant_ack   (grant_ack),
        .overrun     (overrun)
    );

    task automatic step();
        @(posedge OCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - s);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        wr_en = 1'b0;
        grant_ack = 1'b0;
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Drives a write in the current cycle; the caller sets run beforehand.
    task automatic write_ch(input int ch, input int data);
        wr_en = 1'b1;
        wr_sel = 2'(ch);
        wr_data = CNT_W'(data);
        step();
        wr_en = 1'b0;
    endtask

    // Advances to relative cycle last, comparing every tick on ch with the queue head.
    task automatic watch_to(input int ch, input int last);
        while (cyc - s < last) begin
            step();
            if (tick[ch]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_tick ch%0d: got tick at cycle %0d expected none", ch, cyc - s);
                end else begin
                    chk($sformatf("tick_cycle_ch%0d", ch), 32'(cyc - s), exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic check_drained(input string name);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] gid_exp;
        int t;

        vecs[0] = '{ch: 1, wdata: 5,  pe: 5};
        vecs[1] = '{ch: 2, wdata: 0,  pe: 2};
        vecs[2] = '{ch: 2, wdata: 1,  pe: 2};
        vecs[3] = '{ch: 0, wdata: 3,  pe: 3};
        vecs[4] = '{ch: 3, wdata: 7,  pe: 7};
        vecs[5] = '{ch: 1, wdata: 2,  pe: 2};
        vecs[6] = '{ch: 0, wdata: 20, pe: 20};

        // Reset state
        do_reset();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);

        // Table: write at cycle 0 with run high, expect three ticks at 1+k*Pe
        for (int v = 0; v < 7; v++) begin
            do_reset();
            run = 1'b1;
            s = cyc;
            write_ch(vecs[v].ch, vecs[v].wdata);
            for (int k = 1; k <= 3; k++) exp_q.push_back(32'(1 + k * vecs[v].pe));
            watch_to(vecs[v].ch, 1 + 3 * vecs[v].pe);
            check_drained($sformatf("table%0d_missing_ticks", v));
            chk($sformatf("table%0d_level", v), 32'(level[vecs[v].ch]), 32'd1);
        end

        // Default period on channel 0
        do_reset();
        run = 1'b1;
        s = cyc;
        exp_q.push_back(32'd8192);
        exp_q.push_back(32'd16384);
        watch_to(0, 8191);
        chk("def_level_8191", 32'(level[0]), 32'd0);
        watch_to(0, 8192);
        chk("def_level_8192", 32'(level[0]), 32'd1);
        watch_to(0, 16383);
        chk("def_level_16383", 32'(level[0]), 32'd1);
        watch_to(0, 16384);
        chk("def_level_16384", 32'(level[0]), 32'd0);
        check_drained("def_missing_ticks");

        // Arbiter: channels 0..2 tick together once, handler acks one cycle after each grant
        do_reset();
        write_ch(0, 4);
        write_ch(1, 4);
        write_ch(2, 4);
        run = 1'b1;
        s = cyc;
        repeat (4) step();
        run = 1'b0;
        chk("arb_ticks", 32'(tick), 32'b0111);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd2);
        for (int g = 0; g < 3; g++) begin
            gid_exp = 2'(exp_q.pop_front());
            t = 0;
            while (!grant_valid && t < 20) begin
                step();
                t++;
            end
            if (!grant_valid) begin
                n_checks++;
                n_errors++;
                $display("FAIL grant_timeout: got no grant expected grant %0d", gid_exp);
            end else begin
                chk("grant_id", 32'(grant_id), 32'(gid_exp));
                chk("grant_cycle", 32'(cyc - s), 32'(6 + 3 * g));
                step();
                chk("grant_hold", 32'({grant_valid, grant_id}), 32'({1'b1, gid_exp}));
                grant_ack = 1'b1;
                step();
                grant_ack = 1'b0;
                chk("grant_gap", 32'(grant_valid), 32'd0);
            end
        end
        repeat (3) step();
        chk("arb_idle_after", 32'(grant_valid), 32'd0);
        chk("arb_overrun", 32'(overrun), 32'd0);

        // Overrun: P0=3, no ack; second tick sets overrun, a write clears it
        do_reset();
        run = 1'b1;
        s = cyc;
        write_ch(0, 3);
        repeat (6) step();
        chk("ovr_tick7", 32'(tick[0]), 32'd1);
        chk("ovr_before", 32'(overrun), 32'd0);
        step();
        chk("ovr_set", 32'(overrun), 32'b0001);
        chk("ovr_grant", 32'({grant_valid, grant_id}), 32'({1'b1, 2'd0}));
        write_ch(0, 3);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        chk("ovr_wrap_suppressed", 32'(tick[0]), 32'd0);

        // Reset in the middle of a grant discards the programmed period
        chk("midrst_pre_grant", 32'(grant_valid), 32'd1);
        do_reset();
        chk("midrst_grant_valid", 32'(grant_valid), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        run = 1'b1;
        s = cyc;
        watch_to(0, 40);
        check_drained("midrst_queue");

        // Write to ch3 exactly when its counter sits at Pe-1
        do_reset();
        run = 1'b1;
        s = cyc;
        write_ch(3, 6);
        repeat (5) step();
        write_ch(3, 6);
        chk("wrwrap_no_tick", 32'(tick[3]), 32'd0);
        exp_q.push_back(32'd13);
        watch_to(3, 14);
        check_drained("wrwrap_missing_ticks");

        // Pause run for 10 cycles mid-count
        do_reset();
        run = 1'b1;
        s = cyc;
        write_ch(1, 5);
        exp_q.push_back(32'd6);
        exp_q.push_back(32'd21);
        exp_q.push_back(32'd26);
        watch_to(1, 8);
        run = 1'b0;
        watch_to(1, 18);
        run = 1'b1;
        watch_to(1, 27);
        check_drained("pause_missing_ticks");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Runtime-programmable replacement for the fixed power-of-two clock divider.
- Generates four single-cycle enable strobes (input scan I, LED L, display D, timer T) plus 50%-duty level outputs, all from the single system clock OCLK.
- Serialises strobe service to one shared handler through a round-robin pending/grant/ack arbiter, and flags missed services.
- Sits between OCLK and the input-scan, LED, display and timer logic; downstream logic uses strobes as clock enables, not as clocks.

Parameters:
- CNT_W, 26, width of period registers and counters (covers 50,000,000).
- DEF_I, 8192, reset period of channel 0 (I), in OCLK cycles.
- DEF_L, 65536, reset period of channel 1 (L).
- DEF_D, 32768, reset period of channel 2 (D).
- DEF_T, 50000000, reset period of channel 3 (T); 1 s at 50 MHz.

Ports:
- OCLK  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = counters advance; 0 = all counters hold.
- wr_en  in  1  period write strobe.
- wr_sel  in  2  channel index for the write.
- wr_data  in  CNT_W  new period, in cycles.
- tick  out  4  one-cycle strobe per channel.
- level  out  4  square wave per channel; toggles on each tick.
- grant_valid  out  1  a grant is outstanding.
- grant_id  out  2  channel being granted.
- grant_ack  in  1  handler has finished the granted channel.
- overrun  out  4  sticky per-channel missed-service flag.

Behaviour:
- Reset (sync, when reset=1 at a rising edge):
  - P[i] = DEF_x; C[i] = 0.
  - tick, level, pend, overrun = 0.
  - grant_valid = 0; grant_id = 0; rr_last = 3.
  - Reset applied mid-operation discards all state, including programmed periods.
- Effective period: Pe = max(P, 2). Writes of 0 or 1 behave as 2.
- Counter, per channel:
  - If run=1 and no write to this channel: C wraps from Pe-1 to 0, otherwise increments.
  - If run=0: C holds.
- tick (registered): tick[i] is 1 in cycle n+1 iff run=1, C==Pe-1 and no write to channel i in cycle n.
  - With run high from C=0 at cycle 0, the first tick is in cycle Pe, then every Pe cycles.
- level[i] toggles on the cycle tick[i] is 1, giving period 2·Pe.
- Write (wr_en=1):
  - P[wr_sel] = wr_data and C[wr_sel] = 0 next cycle; accepted regardless of run.
  - The write wins over a same-cycle wrap, so that wrap produces no tick.
  - The write clears overrun[wr_sel]; level is unchanged.
- pend[i]:
  - Set when tick[i]=1.
  - Cleared on an accepted ack for channel i.
  - If set and clear occur in the same cycle, set wins.
- overrun[i]: set when tick[i]=1 while pend[i] is already 1 and is not being cleared that cycle. Sticky until reset or a write to channel i.
- Arbiter FSM:
  - IDLE: if any pend, choose the first pending channel searching from rr_last+1 upward with wrap. Next cycle: grant_valid=1, grant_id=choice, state GRANT.
  - GRANT: grant_id is held stable. grant_ack=1 clears pend[grant_id], sets rr_last=grant_id, and sets grant_valid=0 next cycle (state IDLE).
  - Consecutive grants are therefore separated by at least one cycle with grant_valid=0.
  - grant_ack in IDLE is ignored.
  - run=0 does not stall the arbiter.
- Widths: counters and compare are CNT_W unsigned; no overflow because C < Pe ≤ 2^CNT_W-1.

Decomposition:
- Package tick_sched_pkg:
  - CH_I=0, CH_L=1, CH_D=2, CH_T=3.
  - Default period constants.
  - Arbiter state encoding (IDLE, GRANT).
- Sub-module tick_channel, instantiated 4×: period register, counter, tick and level for one channel.
- The top level holds pend, overrun and the arbiter.

Test Plan:
- Reset then run=1 with defaults: first tick[0] at cycle 8192, next at 16384; level[0] high from cycle 8192 to 16383.
- Write P=5 to ch1 at cycle 0, run=1: tick[1] at cycles 6, 11, 16. Write P=0 to ch2: ticks every 2 cycles.
- P0=P1=P2=4 written together, run=1, grant_ack asserted 1 cycle after each grant: grants in order 0,1,2, each separated by an idle cycle; overrun stays 0.
- P0=3, grant_ack held low: second tick[0] sets overrun[0]=1; a later write to ch0 clears it.
- Write to ch3 in the exact cycle C3==Pe-1: no tick[3] follows; the next tick is Pe cycles after the write.
- run dropped to 0 mid-count for 10 cycles: tick timing shifts by exactly 10 cycles. Assert reset mid-GRANT: grant_valid=0 and P restored to defaults next cycle.
